// File: rtl/ysyx_24100012_lsu.sv
// ysyx_24100012_lsu -- load-store unit in front of the data RAM.
//
// Takes one load/store at a time from the EXU (req_* valid/ready), rejects
// misaligned, out-of-window and illegal-funct3 requests without touching the
// RAM, otherwise drives the RAM pins for 1+MEM_LATENCY cycles and returns the
// extended load data (or a store ack) on the resp_* valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake; req_wen, req_funct3, req_addr,
//                          req_wdata are sampled on the accept edge
//   resp_valid/resp_ready  response handshake; resp_rdata, resp_err
//   mem_wen, mem_length,   RAM write strobe, access length in bytes,
//   mem_addr, mem_wdata    shared read/write address, store data
//   mem_rdata              RAM read data, right-aligned
module ysyx_24100012_lsu #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE    = 32'h0800_0000,
  parameter int                    MEM_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0]            LAT_LAST = MEM_LATENCY[3:0];
  // One past the last legal byte, one bit wider so the sum cannot wrap.
  localparam logic [ADDR_WIDTH:0]   LIMIT    = {1'b0, ORIGIN_ADDR} + {1'b0, MEM_SIZE};
  localparam logic [DATA_WIDTH-1:0] LEN_IDLE = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

  logic [1:0]            state_r;
  logic [3:0]            cnt_r;
  logic                  wen_r;
  logic [2:0]            funct3_r;
  logic                  resp_valid_r;
  logic                  resp_err_r;
  logic [DATA_WIDTH-1:0] resp_rdata_r;
  logic                  mem_wen_r;
  logic [DATA_WIDTH-1:0] mem_length_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;

  logic [2:0]            len_s;
  logic                  illegal_s;
  logic                  misalign_s;
  logic [ADDR_WIDTH:0]   end_s;
  logic                  err_s;

  // Sign/zero extension of the right-aligned RAM data according to funct3.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    case (f3)
      3'b000:  r = {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b001:  r = {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode length and error conditions of the incoming request.
  always_comb begin
    len_s      = 3'd4;
    illegal_s  = 1'b0;
    misalign_s = 1'b0;
    case (req_funct3[1:0])
      2'b00:   len_s = 3'd1;
      2'b01:   len_s = 3'd2;
      default: len_s = 3'd4;
    endcase
    case (req_funct3)
      3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
      default:                illegal_s = req_wen & req_funct3[2];
    endcase
    if (req_funct3[1:0] == 2'b01) begin
      misalign_s = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misalign_s = |req_addr[1:0];
    end else begin
      misalign_s = 1'b0;
    end
    end_s = {1'b0, req_addr} + {{(ADDR_WIDTH-2){1'b0}}, len_s};
    err_s = illegal_s | misalign_s | (req_addr < ORIGIN_ADDR) | (end_s > LIMIT);
  end

  // Request FSM; all outputs are registered, mem_* return to idle values on leaving ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      wen_r        <= 1'b0;
      funct3_r     <= 3'd0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {DATA_WIDTH{1'b0}};
      mem_wen_r    <= 1'b0;
      mem_length_r <= LEN_IDLE;
      mem_addr_r   <= ORIGIN_ADDR;
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            wen_r    <= req_wen;
            funct3_r <= req_funct3;
            if (err_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= {DATA_WIDTH{1'b0}};
            end else begin
              state_r      <= ACCESS;
              cnt_r        <= 4'd0;
              mem_wen_r    <= req_wen;
              mem_length_r <= {{(DATA_WIDTH-3){1'b0}}, len_s};
              mem_addr_r   <= req_addr;
              mem_wdata_r  <= req_wen ? req_wdata : {DATA_WIDTH{1'b0}};
            end
          end
        end
        ACCESS: begin
          // The write strobe only lives in the first ACCESS cycle.
          mem_wen_r <= 1'b0;
          cnt_r     <= cnt_r + 4'd1;
          if (cnt_r == LAT_LAST) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= wen_r ? {DATA_WIDTH{1'b0}} : load_extend(funct3_r, mem_rdata);
            mem_length_r <= LEN_IDLE;
            mem_addr_r   <= ORIGIN_ADDR;
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          mem_wen_r    <= 1'b0;
          mem_length_r <= LEN_IDLE;
          mem_addr_r   <= ORIGIN_ADDR;
          mem_wdata_r  <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign req_ready  = rst_n && (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_wen    = mem_wen_r;
  assign mem_length = mem_length_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Scoreboard bench: instance 0 has MEM_LATENCY=0, instance 1 has MEM_LATENCY=3.
// A byte-addressed model RAM is shared by both instances.
module tb_ysyx_24100012_lsu;

  localparam logic [31:0] ORIGIN = 32'h8000_0000;

  logic        clk;
  logic [1:0]  rst_n, req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err, mem_wen;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2];
  logic [31:0] mem_length [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  logic [7:0] ram [logic [31:0]];
  int cyc, pass_cnt, total_cnt;
  int wen_cnt [2];
  int wen_len [2];
  int addr_moved [2];
  int watch_cnt;
  bit prev_v [2];

  ysyx_24100012_lsu #(.MEM_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .mem_wen(mem_wen[0]),
    .mem_length(mem_length[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]));

  ysyx_24100012_lsu #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .mem_wen(mem_wen[1]),
    .mem_length(mem_length[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a, input logic [31:0] len);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++)
      if (k < int'(len) && ram.exists(a + k)) r[8*k +: 8] = ram[a + k];
    return r;
  endfunction

  // Model RAM: combinational-style read refreshed mid-cycle, write on the clock edge.
  always @(negedge clk)
    for (int i = 0; i < 2; i++) mem_rdata[i] = rd(mem_addr[i], mem_length[i]);

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (mem_wen[i])
        for (int k = 0; k < 4; k++)
          if (k < int'(mem_length[i])) ram[mem_addr[i] + k] = mem_wdata[i][8*k +: 8];

  // Monitor: pin statistics and scoreboard comparison of responses.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wen[i]) begin
        wen_cnt[i]++;
        wen_len[i] = int'(mem_length[i]);
      end
      if (mem_addr[i] != ORIGIN) addr_moved[i]++;
      if (i == 1 && mem_addr[1] == 32'h8000_0010) watch_cnt++;
      if (!rst_n[i]) begin
        prev_v[i] = 1'b0;
      end else if (resp_valid[i]) begin
        if (q.size() == 0 || q[0].inst != i) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          if (!prev_v[i]) chk("resp_latency", cyc, q[0].cyc);
          chk("resp_rdata", resp_rdata[i], q[0].rdata);
          chk("resp_err", {31'd0, resp_err[i]}, {31'd0, q[0].err});
          if (resp_ready[i]) void'(q.pop_front());
        end
        prev_v[i] = 1'b1;
      end else begin
        prev_v[i] = 1'b0;
      end
    end
  end

  task automatic issue(input int i, input logic wen, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
    int n;
    int lat;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", {31'd0, req_ready[i]}, 32'd1);
    wen_cnt[i] = 0;
    addr_moved[i] = 0;
    watch_cnt = 0;
    req_valid[i] = 1'b1;
    req_wen[i] = wen;
    req_funct3[i] = f3;
    req_addr[i] = a;
    req_wdata[i] = wd;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    // Response expected in cycle E+1 (error) or E+2+LAT; first seen at the negedge with cyc==E+lat.
    lat = ee ? 0 : (i == 0 ? 1 : 4);
    q.push_back('{i, er, ee, cyc + lat});
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic load0(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] er);
    issue(0, 1'b0, f3, a, 32'h0, er, 1'b0);
    wait_done();
    chk("load_no_wen", wen_cnt[0], 0);
  endtask

  task automatic err0(input logic wen, input logic [2:0] f3, input logic [31:0] a);
    issue(0, wen, f3, a, 32'h1234_5678, 32'h0, 1'b1);
    wait_done();
    chk("err_no_wen", wen_cnt[0], 0);
    chk("err_addr_idle", addr_moved[0], 0);
  endtask

  initial begin
    int n;
    cyc = 0;
    pass_cnt = 0;
    total_cnt = 0;
    watch_cnt = 0;
    rst_n = 2'b00;
    req_valid = 2'b00;
    req_wen = 2'b00;
    resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_funct3[i] = 3'd0;
      req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0;
      mem_rdata[i] = 32'h0;
      wen_cnt[i] = 0;
      wen_len[i] = 0;
      addr_moved[i] = 0;
      prev_v[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    rst_n = 2'b11;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("idle_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    chk("idle_mem_addr", mem_addr[0], ORIGIN);
    chk("idle_mem_length", mem_length[0], 32'd4);
    chk("idle_mem_wen", {31'd0, mem_wen[0]}, 32'd0);
    chk("idle_mem_wdata", mem_wdata[0], 32'd0);

    // Store word, then the five load flavours of the same location.
    issue(0, 1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    wait_done();
    chk("sw_wen_cycles", wen_cnt[0], 1);
    chk("sw_wen_length", wen_len[0], 4);
    load0(3'b000, 32'h8000_0010, 32'hFFFF_FFEF);
    load0(3'b100, 32'h8000_0010, 32'h0000_00EF);
    load0(3'b001, 32'h8000_0010, 32'hFFFF_BEEF);
    load0(3'b101, 32'h8000_0010, 32'h0000_BEEF);
    load0(3'b010, 32'h8000_0010, 32'hDEAD_BEEF);
    load0(3'b000, 32'h8000_0013, 32'hFFFF_FFDE);
    load0(3'b101, 32'h8000_0012, 32'h0000_DEAD);

    // Store halfword and byte, checked by a word load.
    issue(0, 1'b1, 3'b001, 32'h8000_0100, 32'h0000_8001, 32'h0, 1'b0);
    wait_done();
    chk("sh_wen_length", wen_len[0], 2);
    issue(0, 1'b1, 3'b000, 32'h8000_0103, 32'hFFFF_FF7E, 32'h0, 1'b0);
    wait_done();
    chk("sb_wen_length", wen_len[0], 1);
    load0(3'b010, 32'h8000_0100, 32'h7E00_8001);

    // Window boundaries: last legal byte/half/word, then just outside.
    load0(3'b010, 32'h87FF_FFFC, 32'h0);
    load0(3'b100, 32'h87FF_FFFF, 32'h0);
    load0(3'b001, 32'h87FF_FFFE, 32'h0);

    // Error cases: misaligned, below/above window, wrap, illegal funct3.
    err0(1'b0, 3'b010, 32'h8000_0002);
    err0(1'b1, 3'b001, 32'h8000_0001);
    err0(1'b0, 3'b010, 32'h7FFF_FFFC);
    err0(1'b0, 3'b010, 32'h8800_0000);
    err0(1'b0, 3'b101, 32'h87FF_FFFF);
    err0(1'b1, 3'b010, 32'hFFFF_FFFC);
    err0(1'b0, 3'b011, 32'h8000_0000);
    err0(1'b0, 3'b110, 32'h8000_0000);
    err0(1'b1, 3'b100, 32'h8000_0000);

    // MEM_LATENCY=3 load with a stalled consumer.
    resp_ready[1] = 1'b0;
    issue(1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    n = 0;
    while (!resp_valid[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("lat3_mem_addr_cycles", watch_cnt, 4);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", {31'd0, req_ready[1]}, 32'd0);
      chk("stall_resp_valid", {31'd0, resp_valid[1]}, 32'd1);
    end
    resp_ready[1] = 1'b1;
    wait_done();
    chk("lat3_no_wen", wen_cnt[1], 0);

    // Reset while a store is in its write cycle.
    req_valid[1] = 1'b1;
    req_wen[1] = 1'b1;
    req_funct3[1] = 3'b010;
    req_addr[1] = 32'h8000_0020;
    req_wdata[1] = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("wen_before_reset", {31'd0, mem_wen[1]}, 32'd1);
    #1;
    rst_n[1] = 1'b0;
    #1;
    chk("wen_after_reset", {31'd0, mem_wen[1]}, 32'd0);
    chk("reset_mem_addr", mem_addr[1], ORIGIN);
    chk("reset_req_ready", {31'd0, req_ready[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    chk("post_reset_req_ready", {31'd0, req_ready[1]}, 32'd1);
    issue(1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0, 1'b0);
    wait_done();
    issue(1, 1'b0, 3'b001, 32'h8000_0012, 32'h0, 32'hFFFF_DEAD, 1'b0);
    wait_done();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_24100012_lsu.md
Name: ysyx_24100012_lsu

Overview:
Load-store unit sitting directly upstream of the DPI-backed data RAM (ysyx_24100012_ram). It accepts one load or store request at a time from the EXU over a valid/ready handshake and checks alignment and address range. It drives the RAM's address, length, write-data and write-enable pins, then returns a sign/zero-extended load result or a store acknowledgement over a second valid/ready handshake. It guarantees MemWEn is a single-cycle strobe and that the RAM never sees an out-of-range address.

Parameters:
ADDR_WIDTH, 32, address width; equals the RAM's ADDR_WIDTH
DATA_WIDTH, 32, data width; equals the RAM's DATA_WIDTH
ORIGIN_ADDR, 32'h8000_0000, lowest legal byte address
MEM_SIZE, 32'h0800_0000, legal window size in bytes
MEM_LATENCY, 0, extra cycles the address is held before mem_rdata is sampled (0..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101 / SB=000 SH=001 SW=010
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal funct3
mem_wen  out  1  to RAM MemWEn
mem_length  out  DATA_WIDTH  to RAM length, in bytes (1/2/4)
mem_addr  out  ADDR_WIDTH  to RAM inaddr and outaddr
mem_wdata  out  DATA_WIDTH  to RAM din
mem_rdata  in  DATA_WIDTH  from RAM dout, right-aligned

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (rst_n low, asynchronous) forces IDLE, cnt=0, latched request=0, resp_err=0, resp_rdata=0.
- Port values in reset or IDLE: resp_valid=0, mem_wen=0, mem_addr=ORIGIN_ADDR, mem_length=4, mem_wdata=0.
- req_ready = rst_n && state==IDLE. There is no skid buffer and no same-cycle accept-after-response.
- IDLE, on req_valid: latch wen, funct3, addr, wdata.
  - Length is 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
  - Error if any of:
    - funct3 is 011, 110 or 111;
    - a store has funct3[2]=1;
    - a halfword access has addr[0]≠0;
    - a word access has addr[1:0]≠0;
    - addr < ORIGIN_ADDR;
    - addr+len > ORIGIN_ADDR+MEM_SIZE. Compute this check in ADDR_WIDTH+1 bits so it cannot wrap.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. No RAM access occurs.
  - Otherwise: go to ACCESS with cnt=0.
- ACCESS: mem_addr, mem_length and mem_wdata (stores only) are driven from the latched request and held stable for the whole state.
  - mem_wen=1 only when latched wen=1 and cnt==0, giving exactly one cycle per store.
  - cnt increments each cycle.
  - At the edge ending the cycle with cnt==MEM_LATENCY, go to RESP. On a load, capture resp_rdata:
    - LB: sign-extend bits [7:0].
    - LBU: zero-extend bits [7:0].
    - LH: sign-extend bits [15:0].
    - LHU: zero-extend bits [15:0].
    - LW: all 32 bits.
  - On a store, resp_rdata=0 and resp_err=0.
- Latency: request accepted at edge E gives resp_valid at cycle E+2+MEM_LATENCY. On error, resp_valid comes at cycle E+1.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1 is sampled, then the state returns to IDLE. Mem outputs return to their IDLE values.
- resp_ready may be high before resp_valid; it has no effect outside RESP.
- Reset mid-ACCESS drops mem_wen immediately and asynchronously, and the transaction is lost.
- Inputs other than req_valid are don't-care outside the accept cycle.

Test Plan:
- Reset → req_ready=1 and resp_valid=0 after rst_n rises; mem_addr=0x80000000, mem_length=4, mem_wen=0.
- SW addr=0x80000010 wdata=0xDEADBEEF, MEM_LATENCY=0 → mem_wen high exactly 1 cycle with length=4. resp_valid 2 cycles after accept with rdata=0 and err=0.
- Memory 0x80000010 holds 0xDEADBEEF: LB at 0x80000010 (byte 0xEF) → 0xFFFFFFEF; LBU → 0x000000EF; LH (0xBEEF) → 0xFFFFBEEF; LHU → 0x0000BEEF; LW → 0xDEADBEEF.
- LW at 0x80000002, SH at 0x80000001, and LW at 0x7FFFFFFC → resp_err=1 one cycle after accept; mem_wen never asserted; mem_addr stays 0x80000000.
- MEM_LATENCY=3, LW with resp_ready held low 5 cycles → mem_addr stable 4 cycles. resp_valid at accept+5, data held until resp_ready, and req_ready stays 0 throughout.
- Assert rst_n low in ACCESS during an SW → mem_wen drops in the same cycle; state returns to IDLE; the next request completes normally.
